// File: rtl/rbk_wr_req_rx_pkg.sv
// Shared definitions for the RUBIK write-request receiver: packet layout,
// mask constants, FSM states and saturating-counter helpers.
package rbk_wr_pkg;

    localparam int RBK_AW    = 64;
    localparam int RBK_LEN_W = 13;
    localparam int RBK_DW    = 512;
    localparam int RBK_PD_W  = RBK_DW + 3;

    localparam logic PKT_ID_CMD  = 1'b0;
    localparam logic PKT_ID_DATA = 1'b1;

    localparam int PKT_ID_BIT    = 514;
    localparam int PKT_ADDR_LSB  = 0;
    localparam int PKT_ADDR_MSB  = 63;
    localparam int PKT_SIZE_LSB  = 64;
    localparam int PKT_SIZE_MSB  = 76;
    localparam int PKT_LAST_BIT  = 77;
    localparam int PKT_MASK_LSB  = 512;
    localparam int PKT_MASK_MSB  = 513;

    localparam logic [1:0] MASK_FULL = 2'b11;
    localparam logic [1:0] MASK_HALF = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } rx_state_e;

    function automatic logic [31:0] sat_add32(input logic [31:0] cnt, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        if (sum[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction

    function automatic logic [1:0] popcnt2(input logic [1:0] m);
        return {1'b0, m[1]} + {1'b0, m[0]};
    endfunction

endpackage

// File: rtl/rbk_wr_req_rx_if.sv
// Bundle of the packet input stream and the split aw/w output channels.
// slave = receiver side, master = packet source / memory-interface side.
interface rbk_wr_req_rx_if #(
    parameter int AW    = rbk_wr_pkg::RBK_AW,
    parameter int LEN_W = rbk_wr_pkg::RBK_LEN_W,
    parameter int DW    = rbk_wr_pkg::RBK_DW
);
    logic              wr_req_vld;
    logic              wr_req_rdy;
    logic [DW+2:0]     wr_req_pd;

    logic              aw_vld;
    logic              aw_rdy;
    logic [AW-1:0]     aw_addr;
    logic [LEN_W:0]    aw_len;

    logic              w_vld;
    logic              w_rdy;
    logic [DW-1:0]     w_data;
    logic [1:0]        w_mask;
    logic              w_last;

    modport slave (
        input  wr_req_vld, wr_req_pd, aw_rdy, w_rdy,
        output wr_req_rdy, aw_vld, aw_addr, aw_len, w_vld, w_data, w_mask, w_last
    );

    modport master (
        output wr_req_vld, wr_req_pd, aw_rdy, w_rdy,
        input  wr_req_rdy, aw_vld, aw_addr, aw_len, w_vld, w_data, w_mask, w_last
    );
endinterface

// File: rtl/rbk_wr_req_rx_oreg.sv
// One-entry valid/ready output register; a load in the same cycle as a
// downstream handshake keeps valid high, giving one transfer per cycle.
module rbk_wr_rx_oreg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    output logic         can_load_o,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_data_o
);
    logic         vld_q;
    logic         vld_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    assign can_load_o = ~vld_q | out_rdy_i;
    assign out_vld_o  = vld_q;
    assign out_data_o = data_q;

    // next-state of the holding register
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (load_i) begin
            vld_d  = 1'b1;
            data_d = load_data_i;
        end else if (out_rdy_i) begin
            vld_d  = 1'b0;
        end else begin
            vld_d  = vld_q;
        end
    end

    // holding register state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            data_q <= {W{1'b0}};
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/rbk_wr_req_rx.sv
// RUBIK write-request receiver: decodes cmd/data packets, checks beats against
// the command and re-emits them on aw/w. Optional counters: RBK_WR_RX_PERF_EN.
module rbk_wr_req_rx
    import rbk_wr_pkg::*;
#(
    parameter int AW    = RBK_AW,
    parameter int LEN_W = RBK_LEN_W,
    parameter int DW    = RBK_DW
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    rbk_wr_req_rx_if.slave        bus,
    output logic                  wr_done,
    output logic                  proto_err
`ifdef RBK_WR_RX_PERF_EN
    ,
    output logic [31:0]           rx_cmd_cnt,
    output logic [31:0]           rx_atom_cnt,
    output logic [31:0]           rx_stall_cnt
`endif
);
    localparam int AWP_W = AW + LEN_W + 1;
    localparam int WP_W  = DW + 4;

    rx_state_e      state_q;
    rx_state_e      state_d;
    logic [LEN_W:0] atoms_q;
    logic [LEN_W:0] atoms_d;
    logic           last_q;
    logic           last_d;
    logic [LEN_W-1:0] beat_q;
    logic [LEN_W-1:0] beat_d;
    logic           err_q;
    logic           err_d;

    logic           pkt_is_data_s;
    logic [1:0]     pkt_mask_s;
    logic           rdy_s;
    logic           acc_s;
    logic [LEN_W:0] beats_total_s;
    logic           final_beat_s;
    logic [1:0]     exp_mask_s;
    logic           aw_load_s;
    logic           w_load_s;
    logic           aw_can_s;
    logic           w_can_s;
    logic [AWP_W-1:0] aw_in_s;
    logic [AWP_W-1:0] aw_out_s;
    logic [WP_W-1:0]  w_in_s;
    logic [WP_W-1:0]  w_out_s;

    assign pkt_is_data_s = (bus.wr_req_pd[PKT_ID_BIT] == PKT_ID_DATA);
    assign pkt_mask_s    = bus.wr_req_pd[PKT_MASK_MSB:PKT_MASK_LSB];

    // Out-of-place packets are always consumed so the stream can never wedge.
    assign rdy_s = (state_q == ST_IDLE) ? (pkt_is_data_s | aw_can_s)
                                        : (~pkt_is_data_s | w_can_s);
    assign acc_s = bus.wr_req_vld & rdy_s;
    assign bus.wr_req_rdy = rdy_s;

    assign beats_total_s = (atoms_q + {{LEN_W{1'b0}}, 1'b1}) >> 1;
    assign final_beat_s  = ({1'b0, beat_q} == (beats_total_s - {{LEN_W{1'b0}}, 1'b1}));
    assign exp_mask_s    = (final_beat_s && atoms_q[0]) ? MASK_HALF : MASK_FULL;

    assign aw_in_s = {{1'b0, bus.wr_req_pd[PKT_SIZE_MSB:PKT_SIZE_LSB]} + {{LEN_W{1'b0}}, 1'b1},
                      bus.wr_req_pd[PKT_ADDR_MSB:PKT_ADDR_LSB]};
    // The done flag travels with the beat because a new command may already be latched.
    assign w_in_s  = {final_beat_s & last_q, final_beat_s, pkt_mask_s, bus.wr_req_pd[DW-1:0]};

    // FSM next-state and packet decode
    always_comb begin
        state_d   = state_q;
        atoms_d   = atoms_q;
        last_d    = last_q;
        beat_d    = beat_q;
        err_d     = err_q;
        aw_load_s = 1'b0;
        w_load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc_s && pkt_is_data_s) begin
                    err_d = 1'b1;
                end else if (acc_s) begin
                    aw_load_s = 1'b1;
                    atoms_d   = {1'b0, bus.wr_req_pd[PKT_SIZE_MSB:PKT_SIZE_LSB]} + {{LEN_W{1'b0}}, 1'b1};
                    last_d    = bus.wr_req_pd[PKT_LAST_BIT];
                    beat_d    = {LEN_W{1'b0}};
                    state_d   = ST_DATA;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (acc_s && !pkt_is_data_s) begin
                    err_d = 1'b1;
                end else if (acc_s) begin
                    w_load_s = 1'b1;
                    err_d    = err_q | (pkt_mask_s != exp_mask_s);
                    if (final_beat_s) begin
                        beat_d  = {LEN_W{1'b0}};
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and command-context registers
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q <= ST_IDLE;
            atoms_q <= {(LEN_W+1){1'b0}};
            last_q  <= 1'b0;
            beat_q  <= {LEN_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            atoms_q <= atoms_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    rbk_wr_rx_oreg #(.W(AWP_W)) u_aw_reg (
        .clk_i       (nvdla_core_clk),
        .rst_i       (nvdla_core_rst),
        .load_i      (aw_load_s),
        .load_data_i (aw_in_s),
        .can_load_o  (aw_can_s),
        .out_vld_o   (bus.aw_vld),
        .out_rdy_i   (bus.aw_rdy),
        .out_data_o  (aw_out_s)
    );

    rbk_wr_rx_oreg #(.W(WP_W)) u_w_reg (
        .clk_i       (nvdla_core_clk),
        .rst_i       (nvdla_core_rst),
        .load_i      (w_load_s),
        .load_data_i (w_in_s),
        .can_load_o  (w_can_s),
        .out_vld_o   (bus.w_vld),
        .out_rdy_i   (bus.w_rdy),
        .out_data_o  (w_out_s)
    );

    assign bus.aw_len  = aw_out_s[AWP_W-1:AW];
    assign bus.aw_addr = aw_out_s[AW-1:0];
    assign bus.w_last  = w_out_s[DW+2];
    assign bus.w_mask  = w_out_s[DW+1:DW];
    assign bus.w_data  = w_out_s[DW-1:0];

    assign wr_done   = bus.w_vld & bus.w_rdy & w_out_s[DW+3];
    assign proto_err = err_q;

`ifdef RBK_WR_RX_PERF_EN
    logic [31:0] cmd_cnt_q;
    logic [31:0] atom_cnt_q;
    logic [31:0] stall_cnt_q;

    // saturating traffic and back-pressure counters
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            cmd_cnt_q   <= 32'd0;
            atom_cnt_q  <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            cmd_cnt_q   <= aw_load_s ? sat_add32(cmd_cnt_q, 32'd1) : cmd_cnt_q;
            atom_cnt_q  <= w_load_s ? sat_add32(atom_cnt_q, {30'd0, popcnt2(pkt_mask_s)}) : atom_cnt_q;
            stall_cnt_q <= (bus.wr_req_vld && !rdy_s) ? sat_add32(stall_cnt_q, 32'd1) : stall_cnt_q;
        end
    end

    assign rx_cmd_cnt   = cmd_cnt_q;
    assign rx_atom_cnt  = atom_cnt_q;
    assign rx_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_rbk_wr_req_rx.sv
// Bench for rbk_wr_req_rx: directed vector table, hand-written corner
// sequences and randomized traffic checked against a packet-level model.
`timescale 1ns/1ps
module tb_rbk_wr_req_rx;
    import rbk_wr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_done;
    logic proto_err;
`ifdef RBK_WR_RX_PERF_EN
    logic [31:0] rx_cmd_cnt, rx_atom_cnt, rx_stall_cnt;
`endif

    rbk_wr_req_rx_if bus ();

    rbk_wr_req_rx dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .bus            (bus),
        .wr_done        (wr_done),
        .proto_err      (proto_err)
`ifdef RBK_WR_RX_PERF_EN
        ,
        .rx_cmd_cnt     (rx_cmd_cnt),
        .rx_atom_cnt    (rx_atom_cnt),
        .rx_stall_cnt   (rx_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [527:0] act, input logic [527:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout expected progress", name);
    endtask

    // ---------------- packet-level reference model ----------------
    typedef struct packed { logic [63:0] addr; logic [13:0] len; } aw_t;
    typedef struct packed { logic done; logic last; logic [1:0] mask; logic [511:0] data; } w_t;

    aw_t exp_aw_q[$];
    w_t  exp_w_q[$];
    bit  m_in_cmd;
    int  m_left;
    bit  m_last;
    bit  m_err;

    function automatic void model_pkt(input logic [514:0] pd);
        bit fin;
        logic [1:0] em;
        if (pd[514] == 1'b0) begin
            if (m_in_cmd) begin
                m_err = 1'b1;
            end else begin
                exp_aw_q.push_back({pd[63:0], 14'(pd[76:64]) + 14'd1});
                m_left   = int'(pd[76:64]) + 1;
                m_last   = pd[77];
                m_in_cmd = 1'b1;
            end
        end else if (!m_in_cmd) begin
            m_err = 1'b1;
        end else begin
            fin = (m_left <= 2);
            em  = (m_left == 1) ? 2'b01 : 2'b11;
            if (pd[513:512] != em) m_err = 1'b1;
            exp_w_q.push_back({fin & m_last, fin, pd[513:512], pd[511:0]});
            m_left = m_left - 2;
            if (fin) m_in_cmd = 1'b0;
        end
    endfunction

    function automatic logic [514:0] mk_cmd(input logic [63:0] addr, input logic [12:0] size, input logic last);
        logic [514:0] pd;
        pd = '0;
        pd[63:0]  = addr;
        pd[76:64] = size;
        pd[77]    = last;
        return pd;
    endfunction

    function automatic logic [514:0] mk_data(input logic [511:0] d, input logic [1:0] m);
        return {1'b1, m, d};
    endfunction

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
        return d;
    endfunction

    // ---------------- output monitor ----------------
    int wr_done_cnt, w_beat_idx, wlast_idx, stall_cycles;
    logic [13:0] last_aw_len;
    aw_t e_aw;
    w_t  e_w;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.aw_vld && bus.aw_rdy) begin
                if (exp_aw_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL aw_unexpected: got addr 0x%0h expected none", bus.aw_addr);
                end else begin
                    e_aw = exp_aw_q.pop_front();
                    check("aw_beat", {bus.aw_addr, bus.aw_len}, e_aw);
                end
                last_aw_len = bus.aw_len;
            end
            if (bus.w_vld && bus.w_rdy) begin
                if (exp_w_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL w_unexpected: got mask %b expected none", bus.w_mask);
                end else begin
                    e_w = exp_w_q.pop_front();
                    check("w_beat", {wr_done, bus.w_last, bus.w_mask, bus.w_data}, e_w);
                end
                if (bus.w_last) wlast_idx = w_beat_idx;
                if (wr_done) wr_done_cnt++;
                w_beat_idx++;
            end else if (wr_done) begin
                n_vec++; n_err++;
                $display("FAIL wr_done_spurious: got 1 expected 0");
            end
            if (bus.wr_req_vld && !bus.wr_req_rdy) stall_cycles++;
        end
    end

    // ---------------- downstream ready driver ----------------
    int rdy_mode = 0;
    int aw_hold  = 0;

    initial begin
        bus.aw_rdy = 1'b1;
        bus.w_rdy  = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: begin
                    bus.aw_rdy = ($urandom_range(0, 9) < 7);
                    bus.w_rdy  = ($urandom_range(0, 9) < 7);
                end
                2: begin
                    bus.w_rdy  = ~bus.w_rdy;
                    bus.aw_rdy = (aw_hold == 0);
                    if (aw_hold > 0) aw_hold--;
                end
                default: begin
                    bus.aw_rdy = 1'b1;
                    bus.w_rdy  = 1'b1;
                end
            endcase
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send(input logic [514:0] pd);
        int cyc = 0;
        bit ok = 1'b0;
        model_pkt(pd);
        bus.wr_req_vld = 1'b1;
        bus.wr_req_pd  = pd;
        while (!ok && cyc < 1000) begin
            @(negedge clk);
            ok = bus.wr_req_rdy;
            cyc++;
            @(posedge clk); #1;
        end
        bus.wr_req_vld = 1'b0;
        if (!ok) fail_now("req_accept");
    endtask

    task automatic drain();
        int cyc = 0;
        while ((exp_aw_q.size() != 0 || exp_w_q.size() != 0) && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 3000) fail_now("drain");
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr_req_vld = 1'b0;
        @(posedge clk); #1;
        check("reset_outputs", {bus.aw_vld, bus.w_vld, bus.w_last, wr_done, proto_err}, 5'b00000);
        @(posedge clk); #1;
        exp_aw_q.delete();
        exp_w_q.delete();
        m_in_cmd = 1'b0; m_left = 0; m_last = 1'b0; m_err = 1'b0;
        wr_done_cnt = 0; w_beat_idx = 0; wlast_idx = -1; stall_cycles = 0; last_aw_len = '0;
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [63:0] addr;
        logic [12:0] size;
        logic        last;
        int          nbeats;
        logic [7:0]  masks;     // beat i mask at [2i+:2]; beats beyond 4 use 2'b11
        logic [13:0] exp_len;
        int          exp_wlast;
        logic        exp_err;
        int          exp_done;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [63:0] t0;
        logic [1:0]  m;
        int          sz, nb;

        bus.wr_req_vld = 1'b0;
        bus.wr_req_pd  = '0;

        vecs[0] = '{64'h1000_0000, 13'd3, 1'b1, 2, 8'b0000_1111, 14'd4, 1, 1'b0, 1};
        vecs[1] = '{64'h1000_0040, 13'd2, 1'b1, 2, 8'b0000_0111, 14'd3, 1, 1'b0, 1};
        vecs[2] = '{64'h1000_0040, 13'd2, 1'b1, 2, 8'b0000_1111, 14'd3, 1, 1'b1, 1};
        vecs[3] = '{64'h0000_0020, 13'd0, 1'b0, 1, 8'b0000_0001, 14'd1, 0, 1'b0, 0};
        vecs[4] = '{64'h0000_0060, 13'd1, 1'b0, 1, 8'b0000_0010, 14'd2, 0, 1'b1, 0};
        vecs[5] = '{64'h2000_0000, 13'd4, 1'b1, 3, 8'b0001_0011, 14'd5, 2, 1'b1, 1};
        vecs[6] = '{64'h0000_0000_0000_0100, 13'd5, 1'b1, 3, 8'b0011_1111, 14'd6, 2, 1'b0, 1};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFE0, 13'd8191, 1'b1, 4096, 8'b1111_1111, 14'd8192, 4095, 1'b0, 1};

        for (int v = 0; v < 8; v++) begin
            do_reset();
            rdy_mode = 0;
            send(mk_cmd(vecs[v].addr, vecs[v].size, vecs[v].last));
            for (int b = 0; b < vecs[v].nbeats; b++) begin
                m = (b < 4) ? vecs[v].masks[2*b +: 2] : 2'b11;
                send(mk_data(rand_data(), m));
            end
            drain();
            check($sformatf("vec%0d_aw_len", v), last_aw_len, vecs[v].exp_len);
            check($sformatf("vec%0d_beats", v), w_beat_idx, vecs[v].nbeats);
            check($sformatf("vec%0d_wlast_idx", v), wlast_idx, vecs[v].exp_wlast);
            check($sformatf("vec%0d_proto_err", v), proto_err, vecs[v].exp_err);
            check($sformatf("vec%0d_done_cnt", v), wr_done_cnt, vecs[v].exp_done);
        end

        // stray data in IDLE, then stray cmd inside DATA
        do_reset();
        send(mk_data(rand_data(), 2'b11));
        @(posedge clk); #1;
        check("stray_no_output", {bus.aw_vld, bus.w_vld}, 2'b00);
        check("stray_data_err", proto_err, 1'b1);
        send(mk_cmd(64'h3000_0000, 13'd1, 1'b1));
        send(mk_cmd(64'h4000_0000, 13'd7, 1'b1));
        send(mk_data(rand_data(), 2'b11));
        drain();
        check("stray_cmd_aw_len", last_aw_len, 14'd2);
        check("stray_cmd_done", wr_done_cnt, 1);
        check("stray_cmd_err", proto_err, 1'b1);

        // back-to-back commands under w_rdy toggling and aw_rdy held low
        do_reset();
        aw_hold  = 5;
        rdy_mode = 2;
        for (int c = 0; c < 4; c++) begin
            sz = (c == 0) ? 1 : $urandom_range(0, 7);
            nb = (sz + 2) / 2;
            send(mk_cmd({$urandom(), $urandom()} & ~64'h1F, 13'(sz), 1'b1));
            for (int b = 0; b < nb; b++) begin
                m = (b == nb - 1 && (sz % 2) == 0) ? 2'b01 : 2'b11;
                send(mk_data(rand_data(), m));
            end
        end
        drain();
        check("stall_seen", (stall_cycles > 0), 1'b1);
        check("stall_done_cnt", wr_done_cnt, 4);
        check("stall_err", proto_err, 1'b0);
        rdy_mode = 0;

        // full throughput: two 4-beat commands in 10 cycles
        do_reset();
        @(posedge clk); #1;
        t0 = $time;
        for (int c = 0; c < 2; c++) begin
            send(mk_cmd(64'h5000_0000 + 64'(c) * 64'h100, 13'd7, 1'b1));
            for (int b = 0; b < 4; b++) send(mk_data(rand_data(), 2'b11));
        end
        check("throughput_cycles", ($time - t0) / 10, 10);
        drain();
        check("throughput_done", wr_done_cnt, 2);

        // reset in the middle of a command
        do_reset();
        send(mk_cmd(64'h6000_0000, 13'd7, 1'b1));
        send(mk_data(rand_data(), 2'b11));
        do_reset();
        send(mk_cmd(64'h7000_0000, 13'd1, 1'b1));
        send(mk_data(rand_data(), 2'b11));
        drain();
        check("post_reset_aw_len", last_aw_len, 14'd2);
        check("post_reset_done", wr_done_cnt, 1);
        check("post_reset_err", proto_err, 1'b0);

        // randomized traffic; odd rounds inject protocol violations
        for (int r = 0; r < 6; r++) begin
            do_reset();
            rdy_mode = 1;
            for (int c = 0; c < 25; c++) begin
                sz = $urandom_range(0, 9);
                nb = (sz + 2) / 2;
                if ((r % 2) == 1 && $urandom_range(0, 9) == 0) send(mk_data(rand_data(), 2'b11));
                send(mk_cmd({$urandom(), $urandom()} & ~64'h1F, 13'(sz), 1'($urandom_range(0, 1))));
                for (int b = 0; b < nb; b++) begin
                    m = (b == nb - 1 && (sz % 2) == 0) ? 2'b01 : 2'b11;
                    if ((r % 2) == 1 && $urandom_range(0, 19) == 0) m = 2'($urandom_range(0, 3));
                    if ((r % 2) == 1 && $urandom_range(0, 29) == 0) send(mk_cmd(64'h0, 13'd3, 1'b1));
                    send(mk_data(rand_data(), m));
                end
            end
            drain();
            check($sformatf("rand%0d_proto_err", r), proto_err, m_err);
        end
        rdy_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/rbk_wr_req_rx.md
Name: rbk_wr_req_rx

Overview:
- Receiving end of the RUBIK write-request packet stream: consumes the 515-bit multiplexed cmd/data packets that the write-request generator emits on wr_req_*.
- Decodes each command (address, atom count, last flag), checks the following data beats against it, and re-emits them on split address and data channels toward the memory-interface write path.
- Flags protocol violations and pulses completion when the last data beat of a final command is issued.

Parameters:
- AW, 64, address width (cmd bits [63:0]; bits [4:0] always zero, 32B atom aligned).
- LEN_W, 13, atom-count field width (cmd bits [76:64], value = atoms-1).
- DW, 512, data payload width (two 256-bit atoms per beat).

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rst  in  1  synchronous active-high reset
- wr_req_vld  in  1  packet valid
- wr_req_rdy  out  1  packet ready
- wr_req_pd  in  515  [514] ID, 0=cmd, 1=data; cmd: [63:0] addr, [76:64] size, [77] last; data: [511:0] payload, [513:512] mask
- aw_vld  out  1  address-channel valid
- aw_rdy  in  1  address-channel ready
- aw_addr  out  AW  command address
- aw_len  out  LEN_W+1  atom count (size+1)
- w_vld  out  1  data-channel valid
- w_rdy  in  1  data-channel ready
- w_data  out  DW  beat payload
- w_mask  out  2  atom mask as received
- w_last  out  1  final beat of the current command
- wr_done  out  1  one-cycle pulse: final beat of a last=1 command accepted by w channel
- proto_err  out  1  sticky violation flag, cleared only by reset

Behaviour:
- Reset: state IDLE; aw_vld, w_vld, w_last, wr_done, proto_err = 0; all counters = 0.
- FSM IDLE: expects cmd (ID=0).
  - On cmd handshake, latch addr, atoms = size+1 (14-bit) and last, load the aw output register, go to DATA.
  - Data packet in IDLE: consume, drop, set proto_err.
- FSM DATA: expects beats.
  - beats_total = ceil(atoms/2); beat counter counts up from 0.
  - Expected mask is 2'b01 on the final beat when atoms is odd, otherwise 2'b11.
  - Mismatch, including mask 2'b10 or 2'b00: set proto_err; beat is still forwarded and counted.
  - Cmd packet in DATA: consume, drop, set proto_err; state unchanged.
  - After the final beat handshake, return to IDLE.
- Output registers: aw and w each use a one-entry register.
  - Register loads on input handshake; valid clears on downstream handshake unless reloaded the same cycle (full throughput).
  - Latency: input handshake to output valid is 1 cycle.
- wr_req_rdy (combinational, never depends on wr_req_vld):
  - IDLE: aw register empty or aw_rdy.
  - DATA: w register empty or w_rdy.
  - Dropped packets are always accepted.
- w_last = 1 on the final beat of each command.
- wr_done asserts in the cycle the w handshake occurs with w_last=1 and latched last=1.
- Next command can be accepted the cycle after the final data beat; no bubble beyond the FSM transition.
- aw_len 14 bits: size=8191 gives atoms=8192, beats=4096; beat counter 13 bits, no wrap.
- Downstream stall holds registers stable and deasserts wr_req_rdy; no data loss.

Optional Feature:
- RBK_WR_RX_PERF_EN
- Defined: adds outputs rx_cmd_cnt[31:0], rx_atom_cnt[31:0] and rx_stall_cnt[31:0].
  - rx_stall_cnt counts cycles with wr_req_vld & !wr_req_rdy.
  - All three saturate at 0xFFFFFFFF and clear on reset.
  - rx_atom_cnt adds popcount(mask) per accepted beat.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package rbk_wr_pkg:
  - packet ID constants (CMD=0, DATA=1)
  - field bit positions (ADDR, SIZE, LAST, MASK)
  - mask constants FULL=2'b11, HALF=2'b01
  - FSM state enum
- Sub-module rbk_wr_rx_oreg: the one-entry valid/ready output register, parameterised on width, instantiated for aw and w.

Test Plan:
- cmd addr=0x1000_0000, size=3, last=1, then beats mask 11,11:
  - aw_len=4, then two w beats, w_last on the 2nd.
  - wr_done pulses once; proto_err=0.
- cmd size=2 (3 atoms), beats 11 then 01: aw_len=3, w_last on the 01 beat, no error.
- Same command with final mask 11: beat forwarded, proto_err=1.
- Data packet in IDLE, then cmd in DATA state: both consumed, no aw/w output, proto_err=1, FSM continues.
- Back-to-back cmds with w_rdy toggling every cycle and aw_rdy held 0 for 5 cycles:
  - wr_req_rdy deasserts accordingly, payloads emerge in order and intact.
  - Throughput is 1 beat/cycle when rdy is held at 1.
- Reset asserted mid-DATA after 1 of 4 beats: all outputs 0 next cycle; a new cmd is accepted normally.
